// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity serial receiver: FSM state
// encodings and the frame-length helpers used to size the bit counter.
package parity_pkg;

    // Receiver FSM states; IDLE is the all-zero encoding so a cleared
    // register lands in a safe state.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

    // Non-data bits in every frame: start, parity and stop.
    localparam int unsigned FRAME_OVERHEAD = 3;

    // Total serial bits in one frame for a given data width.
    function automatic int unsigned frame_bits(input int unsigned data_w);
        return data_w + FRAME_OVERHEAD;
    endfunction

    // Frame length for the default 4-bit configuration.
    localparam int unsigned DEFAULT_FRAME_BITS = frame_bits(4);

endpackage : parity_pkg

// File: rtl/parity_rx_bit_timer.sv
// Mid-bit sample timer. A load sets the distance to the first tick (half a
// bit after start detection); after each tick the counter reloads a full bit
// period so later ticks land in the middle of each following bit.
module parity_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Tick on the last cycle of the current interval; a load takes priority.
    assign tick = count && !load && (cnt == ONE);

    // Down-counter with load, auto-reload on tick, and hold when not counting.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count) begin
            if (cnt <= ONE) begin
                cnt <= FULL_BIT;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule : parity_rx_bit_timer

// File: rtl/parity_serial_rx.sv
// Even-parity UART-style receiver: start bit, DATA_W data bits LSB first,
// one even-parity bit, one stop bit. The line is synchronized, sampled at
// mid-bit by the bit timer, and each frame ends with a one-cycle valid pulse
// that also updates the held data word and error flags.
module parity_serial_rx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_BITS = frame_bits(DATA_W);
    localparam int CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic [1:0]        sync;
    logic              rx_s;
    rx_state_t         state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              par_bit;
    logic              armed;
    logic              parity_bad;
    logic              timer_load;
    logic              timer_count;
    logic              tick;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_in};
        end
    end

    assign rx_s = sync[1];

    // Incoming bit enters at the MSB and the word shifts right, so after
    // DATA_W samples the first (LSB) bit has reached bit 0.
    always_comb begin
        // NOTE: a default assignment ahead of any partial update keeps this
        // block purely combinational; without it a latch would be inferred.
        shift_next             = shift_reg >> 1;
        shift_next[DATA_W-1]   = rx_s;
    end

    // Even parity: the data bits plus the parity bit must XOR to zero.
    assign parity_bad = (^shift_reg) ^ par_bit;

    // Start a new frame only on a low line while armed; armed is withheld
    // after a low stop bit until the line has been seen high again.
    assign timer_load  = (state == S_IDLE) && armed && !rx_s;
    assign timer_count = (state != S_IDLE);

    parity_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (HALF_BIT),
        .count    (timer_count),
        .tick     (tick)
    );

    // Frame FSM with registered outputs; all sampling happens on timer ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            armed      <= 1'b1;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (armed && !rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_DATA) begin
                            state <= S_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        data_out   <= shift_reg;
                        parity_err <= parity_bad;
                        frame_err  <= !rx_s;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        armed      <= rx_s;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : parity_serial_rx

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx with DATA_W=4, CLKS_PER_BIT=8.
module tb_parity_serial_rx;

    localparam int DATA_W = 4;
    localparam int CPB    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_in;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    parity_serial_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc;
    int last_valid_cyc;
    int n_valid  = 0;
    int n_double = 0;
    logic busy_seen;
    logic prev_valid = 1'b0;
    logic [DATA_W-1:0] cap_data [32];
    logic              cap_perr [32];
    logic              cap_ferr [32];

    always @(posedge clk) cyc++;

    // Monitor samples outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_seen = 1'b1;
        if (valid === 1'b1) begin
            if (n_valid < 32) begin
                cap_data[n_valid] = data_out;
                cap_perr[n_valid] = parity_err;
                cap_ferr[n_valid] = frame_err;
            end
            if (prev_valid) n_double++;
            n_valid++;
            last_valid_cyc = cyc;
        end
        prev_valid = (valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        rx_in = 1'b1;
    endtask

    int base;
    int lat;

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        idle(3);
        check("reset_data_out",   32'(data_out),   32'h0);
        check("reset_valid",      32'(valid),      32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        check("reset_busy",       32'(busy),       32'h0);
        rst = 1'b0;
        idle(5);

        // Good frame 1010, even parity 0, stop 1.
        base      = n_valid;
        busy_seen = 1'b0;
        send_frame(4'b1010, 1'b0, 1'b1);
        idle(10);
        check("good_valid_count", 32'(n_valid - base), 32'd1);
        check("good_data",        32'(cap_data[base]), 32'hA);
        check("good_perr",        32'(cap_perr[base]), 32'h0);
        check("good_ferr",        32'(cap_ferr[base]), 32'h0);
        check("good_busy_seen",   32'(busy_seen),      32'h1);
        check("good_busy_after",  32'(busy),           32'h0);
        lat = last_valid_cyc - start_cyc;
        check("good_latency_window", 32'(lat >= 54 && lat <= 56), 32'h1);

        // Bad parity: 0111 needs parity 1, send 0.
        base = n_valid;
        send_frame(4'b0111, 1'b0, 1'b1);
        idle(10);
        check("perr_valid_count", 32'(n_valid - base), 32'd1);
        check("perr_data",        32'(cap_data[base]), 32'h7);
        check("perr_perr",        32'(cap_perr[base]), 32'h1);
        check("perr_ferr",        32'(cap_ferr[base]), 32'h0);
        check("perr_hold",        32'(parity_err),     32'h1);

        // Framing error: 0010 parity 1, stop low, line then stays low.
        base = n_valid;
        send_frame(4'b0010, 1'b1, 1'b0);
        rx_in = 1'b0;
        idle(30);
        check("ferr_valid_count", 32'(n_valid - base), 32'd1);
        check("ferr_data",        32'(cap_data[base]), 32'h2);
        check("ferr_perr",        32'(cap_perr[base]), 32'h0);
        check("ferr_ferr",        32'(cap_ferr[base]), 32'h1);
        check("ferr_no_restart_busy", 32'(busy),       32'h0);
        rx_in = 1'b1;
        idle(10);
        check("ferr_no_extra_valid", 32'(n_valid - base), 32'd1);

        // False start: 2-cycle low glitch.
        base      = n_valid;
        busy_seen = 1'b0;
        rx_in     = 1'b0;
        idle(2);
        rx_in = 1'b1;
        idle(CPB / 2 + 3);
        check("glitch_busy_seen",   32'(busy_seen), 32'h1);
        check("glitch_busy_cleared", 32'(busy),     32'h0);
        idle(10);
        check("glitch_no_valid", 32'(n_valid - base), 32'd0);

        // Reset during data bit 2, then a clean 0000 frame.
        base = n_valid;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_in = 1'b0;
        idle(4);
        rst   = 1'b1;
        rx_in = 1'b1;
        idle(3);
        check("midrst_busy",     32'(busy),     32'h0);
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_perr",     32'(parity_err), 32'h0);
        rst = 1'b0;
        idle(20);
        check("midrst_no_valid", 32'(n_valid - base), 32'd0);
        send_frame(4'b0000, 1'b0, 1'b1);
        idle(10);
        check("after_rst_valid_count", 32'(n_valid - base), 32'd1);
        check("after_rst_data",        32'(cap_data[base]), 32'h0);
        check("after_rst_perr",        32'(cap_perr[base]), 32'h0);
        check("after_rst_ferr",        32'(cap_ferr[base]), 32'h0);

        // Back-to-back frames 1111 then 0001.
        base = n_valid;
        send_frame(4'b1111, 1'b0, 1'b1);
        send_frame(4'b0001, 1'b1, 1'b1);
        idle(10);
        check("b2b_valid_count", 32'(n_valid - base),     32'd2);
        check("b2b_data0",       32'(cap_data[base]),     32'hF);
        check("b2b_data1",       32'(cap_data[base + 1]), 32'h1);
        check("b2b_perr0",       32'(cap_perr[base]),     32'h0);
        check("b2b_perr1",       32'(cap_perr[base + 1]), 32'h0);
        check("b2b_ferr1",       32'(cap_ferr[base + 1]), 32'h0);
        check("b2b_data_held",   32'(data_out),           32'h1);

        check("valid_single_cycle", 32'(n_double), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_parity_serial_rx
